// File: rtl/crt_row_fetch.sv
// rtl/crt_row_fetch.sv - DMA row-fetch engine with double-buffered row store and attribute FIFOs
module crt_row_fetch #(
  parameter int MAX_COLS = 80,
  parameter int COL_W    = 7,
  parameter int FIFO_AW  = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              row_start,
  input  logic [COL_W-1:0]  cfg_cols,
  input  logic [1:0]        cfg_burst,
  input  logic [2:0]        cfg_space,
  input  logic              cfg_transp,
  output logic              drq,
  input  logic              dack,
  input  logic [DATA_W-1:0] dma_data,
  input  logic [COL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              fifo_pop,
  output logic [6:0]        fifo_data,
  output logic              underrun,
  output logic              fifo_ovf,
  output logic              eos,
  output logic              busy
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [COL_W:0]   LAST_MAX = (COL_W+1)'(MAX_COLS - 1);
  localparam logic [COL_W:0]   POS_ONE  = (COL_W+1)'(1);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, SPACE, DONE, STOP} state_t;

  state_t state, st_x, nxt_state;
  logic wr_bank, rd_bank;
  logic [COL_W:0] wr_pos, pos_inc, pos_after, last_col;
  logic [COL_W:0] len [2];
  logic [DATA_W-1:0] row_mem [2][MAX_COLS];
  logic [6:0] fifo_mem [2][DEPTH];
  logic [FIFO_AW-1:0] fifo_wp [2];
  logic [FIFO_AW-1:0] fifo_rp [2];
  logic [FIFO_AW:0] fifo_cnt [2];
  logic transp_pend, pend_after;
  logic [2:0] burst_cnt;
  logic [5:0] space_cnt, space_ticks;
  logic [3:0] burst_len;
  logic xfer, is_attr, is_end, is_store, push_ok, pop_ok;
  logic burst_hit, space_hit, swap, set_underrun;

  assign rd_bank   = ~wr_bank;
  assign fifo_data = (fifo_cnt[rd_bank] != '0) ? fifo_mem[rd_bank][fifo_rp[rd_bank]] : 7'd0;

  always_comb begin
    last_col    = ({1'b0, cfg_cols} > LAST_MAX) ? LAST_MAX : {1'b0, cfg_cols};
    xfer        = drq & dack;
    is_attr     = xfer & transp_pend;
    is_end      = xfer & ~transp_pend & (dma_data[7:4] == 4'hF) & dma_data[0];
    is_store    = xfer & ~transp_pend & ~is_end;
    push_ok     = is_attr & (fifo_cnt[wr_bank] != FULL);
    pop_ok      = fifo_pop & (fifo_cnt[rd_bank] != '0);
    pos_inc     = wr_pos + POS_ONE;
    pos_after   = is_store ? pos_inc : wr_pos;
    pend_after  = transp_pend;
    if (is_attr)
      pend_after = 1'b0;
    else if (is_store && dma_data[7:6] == 2'b10 && cfg_transp)
      pend_after = 1'b1;
    burst_len   = 4'd1 << cfg_burst;
    burst_hit   = ({1'b0, burst_cnt} + 4'd1) == burst_len;
    space_ticks = {cfg_space, 3'b000} - 6'd1;
    space_hit   = ce && ((space_cnt + 6'd1) == space_ticks);

    // st_x is the state after this clk's transfer, before row/frame events
    st_x = state;
    case (state)
      REQ: if (xfer) begin
        if (is_end)
          st_x = dma_data[1] ? STOP : DONE;
        else if (pos_after > last_col && !pend_after)
          st_x = DONE;
        else if (burst_hit && cfg_space != 3'd0)
          st_x = SPACE;
      end
      SPACE: if (space_hit) st_x = REQ;
      default: st_x = state;
    endcase

    swap         = row_start & ~frame_start;
    set_underrun = (st_x == REQ) || (st_x == SPACE);
    nxt_state    = st_x;
    if (swap && st_x != STOP && st_x != IDLE)
      nxt_state = REQ;
    if (frame_start)
      nxt_state = enable ? REQ : IDLE;
    if (!enable)
      nxt_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (is_store)
      row_mem[wr_bank][wr_pos[COL_W-1:0]] <= dma_data;
    if (push_ok)
      fifo_mem[wr_bank][fifo_wp[wr_bank]] <= dma_data[6:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      drq         <= 1'b0;
      busy        <= 1'b0;
      rd_data     <= '0;
      underrun    <= 1'b0;
      fifo_ovf    <= 1'b0;
      eos         <= 1'b0;
      wr_bank     <= 1'b0;
      wr_pos      <= '0;
      transp_pend <= 1'b0;
      burst_cnt   <= '0;
      space_cnt   <= '0;
      for (int b = 0; b < 2; b++) begin
        len[b]      <= '0;
        fifo_wp[b]  <= '0;
        fifo_rp[b]  <= '0;
        fifo_cnt[b] <= '0;
      end
    end else begin
      state       <= nxt_state;
      drq         <= (nxt_state == REQ);
      busy        <= (nxt_state == REQ) || (nxt_state == SPACE);
      wr_pos      <= pos_after;
      transp_pend <= pend_after;
      if (is_store)
        len[wr_bank] <= pos_inc;
      if (is_end) begin
        len[wr_bank] <= wr_pos;
        if (dma_data[1]) eos <= 1'b1;
      end
      if (is_attr && !push_ok)
        fifo_ovf <= 1'b1;
      if (push_ok) begin
        fifo_wp[wr_bank]  <= fifo_wp[wr_bank] + 1'b1;
        fifo_cnt[wr_bank] <= fifo_cnt[wr_bank] + 1'b1;
      end
      if (pop_ok) begin
        fifo_rp[rd_bank]  <= fifo_rp[rd_bank] + 1'b1;
        fifo_cnt[rd_bank] <= fifo_cnt[rd_bank] - 1'b1;
      end
      if (xfer)
        burst_cnt <= burst_hit ? 3'd0 : burst_cnt + 3'd1;
      if (state != SPACE)
        space_cnt <= '0;
      else if (ce)
        space_cnt <= space_cnt + 6'd1;
      if ({1'b0, rd_addr} < len[rd_bank])
        rd_data <= row_mem[rd_bank][rd_addr];
      else
        rd_data <= '0;
      // the display bank becomes the write bank and starts clean
      if (swap) begin
        if (set_underrun) underrun <= 1'b1;
        wr_bank           <= rd_bank;
        wr_pos            <= '0;
        len[rd_bank]      <= '0;
        fifo_wp[rd_bank]  <= '0;
        fifo_rp[rd_bank]  <= '0;
        fifo_cnt[rd_bank] <= '0;
        transp_pend       <= 1'b0;
        burst_cnt         <= '0;
      end
      if (frame_start) begin
        underrun    <= 1'b0;
        fifo_ovf    <= 1'b0;
        eos         <= 1'b0;
        transp_pend <= 1'b0;
        wr_pos      <= '0;
        burst_cnt   <= '0;
        for (int b = 0; b < 2; b++) begin
          len[b]      <= '0;
          fifo_wp[b]  <= '0;
          fifo_rp[b]  <= '0;
          fifo_cnt[b] <= '0;
        end
      end
    end
  end
endmodule
